sid_bus_if: RTL and testbench

SID_BUS_IF -- requirements
Module: sid_bus_if

---
 rtl/sid_pkg.sv | 11 +
 rtl/sid_sync.sv | 17 +
 rtl/sid_bus_if.sv | 115 +++++++++++
 tb/tb_sid_bus_if.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sid_pkg.sv
// sid_pkg: shared register addresses, bus FSM states and the readable-register decode helper
package sid_pkg;
  localparam logic [4:0] ADDR_POTX = 5'h19;
  localparam logic [4:0] ADDR_POTY = 5'h1A;
  localparam logic [4:0] ADDR_OSC3 = 5'h1B;
  localparam logic [4:0] ADDR_ENV3 = 5'h1C;
  typedef enum logic [1:0] {IDLE, WR, RD} bus_state_t;
  function automatic logic is_src(input logic [4:0] a);
    return (a >= ADDR_POTX) && (a <= ADDR_ENV3);
  endfunction
endpackage

// File: rtl/sid_sync.sv
// sid_sync: DEPTH-flop synchronizer with a parameterised reset value
//   clk, rst_n (async active-low), d (async input), q (synchronized output)
module sid_sync #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] sr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= {DEPTH{RST_VAL}};
    else sr <= DEPTH'({sr, d});
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/sid_bus_if.sv
// sid_bus_if: asynchronous 6502-style CPU bus to SID register interface with a decaying bus latch
//   clk/iRstN/clkEn : master clock, async active-low reset, 1 MHz tick
//   iCSn/iRW/iPhi2  : asynchronous CPU control, synchronized internally
//   iAddr/iDataIn   : CPU address and write data
//   oData/oDataOE   : registered read data and its output enable
//   oWE/oAddr/oDataW: one-clk register write strobe with held address and data
//   iPotX/iPotY/iOsc3/iEnv3: readable register sources
module sid_bus_if
  import sid_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DECAY_TICKS = 8192
) (
  input  logic       clk,
  input  logic       iRstN,
  input  logic       clkEn,
  input  logic       iCSn,
  input  logic       iRW,
  input  logic       iPhi2,
  input  logic [4:0] iAddr,
  input  logic [7:0] iDataIn,
  output logic [7:0] oData,
  output logic       oDataOE,
  output logic       oWE,
  output logic [4:0] oAddr,
  output logic [7:0] oDataW,
  input  logic [7:0] iPotX,
  input  logic [7:0] iPotY,
  input  logic [7:0] iOsc3,
  input  logic [7:0] iEnv3
);
  localparam int CW = $clog2(DECAY_TICKS + 1);
  logic cs_s, rw_s, phi2_s, phi2_d, rise, fall, commit, rd_done, load;
  bus_state_t state, state_nx;
  logic [4:0] cap_addr;
  logic [7:0] cap_data, bus_latch, rd_mux, load_val;
  logic [CW-1:0] decay_cnt;

  sid_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_cs   (.clk(clk), .rst_n(iRstN), .d(iCSn),  .q(cs_s));
  sid_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_rw   (.clk(clk), .rst_n(iRstN), .d(iRW),   .q(rw_s));
  sid_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_phi2 (.clk(clk), .rst_n(iRstN), .d(iPhi2), .q(phi2_s));

  assign rise = phi2_s & ~phi2_d;
  assign fall = ~phi2_s & phi2_d;

  // Chip select deasserting before the phi2 fall aborts the cycle with no side effects
  always_comb begin
    state_nx = state;
    commit   = 1'b0;
    rd_done  = 1'b0;
    unique case (state)
      IDLE: if (rise && !cs_s) state_nx = rw_s ? RD : WR;
      WR: if (cs_s) state_nx = IDLE;
          else if (fall) begin
            state_nx = IDLE;
            commit   = 1'b1;
          end
      RD: if (cs_s) state_nx = IDLE;
          else if (fall) begin
            state_nx = IDLE;
            rd_done  = 1'b1;
          end
      default: state_nx = IDLE;
    endcase
  end

  always_comb
    rd_mux = (iAddr == ADDR_POTX) ? iPotX :
             (iAddr == ADDR_POTY) ? iPotY :
             (iAddr == ADDR_OSC3) ? iOsc3 :
             (iAddr == ADDR_ENV3) ? iEnv3 : bus_latch;

  // Reads of the live registers refresh the latch with the value the CPU saw
  assign load     = commit | (rd_done & is_src(iAddr));
  assign load_val = commit ? cap_data : oData;
  assign oDataOE  = (state == RD);

  always_ff @(posedge clk or negedge iRstN)
    if (!iRstN) begin
      state    <= IDLE;
      phi2_d   <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
      oWE      <= 1'b0;
      oAddr    <= '0;
      oDataW   <= '0;
      oData    <= '0;
    end else begin
      state  <= state_nx;
      phi2_d <= phi2_s;
      oWE    <= commit;
      oData  <= rd_mux;
      if (state == WR) begin
        cap_addr <= iAddr;
        cap_data <= iDataIn;
      end
      if (commit) begin
        oAddr  <= cap_addr;
        oDataW <= cap_data;
      end
    end

  // A load in the same clk as the final tick takes priority over the decay clear
  always_ff @(posedge clk or negedge iRstN)
    if (!iRstN) begin
      bus_latch <= '0;
      decay_cnt <= '0;
    end else if (load) begin
      bus_latch <= load_val;
      decay_cnt <= CW'(DECAY_TICKS);
    end else if (clkEn && decay_cnt != '0) begin
      decay_cnt <= decay_cnt - CW'(1);
      if (decay_cnt == CW'(1)) bus_latch <= 8'h00;
    end
endmodule

// File: tb/tb_sid_bus_if.sv
// tb_sid_bus_if: self-checking bench for sid_bus_if (vector table, directed corners, random vs. reference model)
module tb_sid_bus_if;
  import sid_pkg::*;
  localparam int DECAY = 20;

  logic clk = 1'b0, iRstN = 1'b0, clkEn = 1'b0, iCSn = 1'b1, iRW = 1'b1, iPhi2 = 1'b0;
  logic [4:0] iAddr = '0;
  logic [7:0] iDataIn = '0, iPotX = 8'h11, iPotY = 8'h22, iOsc3 = 8'hC3, iEnv3 = 8'hE3;
  logic [7:0] oData, oDataW;
  logic [4:0] oAddr;
  logic oDataOE, oWE;

  sid_bus_if #(.SYNC_STAGES(2), .DECAY_TICKS(DECAY)) dut (
    .clk(clk), .iRstN(iRstN), .clkEn(clkEn), .iCSn(iCSn), .iRW(iRW), .iPhi2(iPhi2),
    .iAddr(iAddr), .iDataIn(iDataIn), .oData(oData), .oDataOE(oDataOE), .oWE(oWE),
    .oAddr(oAddr), .oDataW(oDataW), .iPotX(iPotX), .iPotY(iPotY), .iOsc3(iOsc3), .iEnv3(iEnv3)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, we_pulses = 0;
  logic we_prev = 1'b0;
  always @(negedge clk) begin
    if (oWE && !we_prev) we_pulses++;
    we_prev = oWE;
  end

  // Reference model: latch value plus clkEn ticks since its last load
  logic [7:0] m_val = 8'h00;
  int m_ticks = 0;
  function automatic logic [7:0] m_latch();
    return (m_ticks >= DECAY) ? 8'h00 : m_val;
  endfunction
  function automatic logic [7:0] m_read(input logic [4:0] a);
    case (a)
      5'h19: return iPotX;
      5'h1A: return iPotY;
      5'h1B: return iOsc3;
      5'h1C: return iEnv3;
      default: return m_latch();
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk) clkEn = 1'b1;
    @(negedge clk) clkEn = 1'b0;
    m_ticks++;
  endtask

  task automatic bus_open(input logic rw, input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    iAddr = a; iDataIn = d; iRW = rw; iCSn = 1'b0;
    repeat (3) @(negedge clk);
    iPhi2 = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic bus_close();
    iCSn = 1'b1; iRW = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Full bus cycle: phi2 falls at N0, phi2_s falls after the 2nd posedge, FSM acts on the 3rd
  task automatic do_cycle(input logic rw, input logic [4:0] a, input logic [7:0] d, input logic [7:0] exp);
    int p0;
    bus_open(rw, a, d);
    if (rw) begin
      chk("rd_oe", oDataOE, 1);
      chk("rd_data", oData, exp);
    end
    p0 = we_pulses;
    iPhi2 = 1'b0;
    repeat (2) @(negedge clk);
    if (rw) chk("rd_oe_hold", oDataOE, 1); else chk("we_early", oWE, 0);
    @(negedge clk);
    if (rw) chk("rd_oe_clr", oDataOE, 0);
    else begin
      chk("we_pulse", oWE, 1);
      chk("we_addr", oAddr, a);
      chk("we_data", oDataW, d);
    end
    @(negedge clk);
    if (!rw) chk("we_width", oWE, 0);
    bus_close();
    chk("we_count", we_pulses - p0, rw ? 0 : 1);
    if (!rw) begin m_val = d; m_ticks = 0; end
    else if (a >= 5'h19 && a <= 5'h1C) begin m_val = exp; m_ticks = 0; end
  endtask

  task automatic do_abort(input logic rw, input logic [4:0] a, input logic [7:0] d);
    int p0;
    p0 = we_pulses;
    bus_open(rw, a, d);
    iCSn = 1'b1;
    repeat (4) @(negedge clk);
    iPhi2 = 1'b0;
    repeat (4) @(negedge clk);
    iRW = 1'b1;
    chk("abort_we", we_pulses - p0, 0);
    chk("abort_latch", dut.bus_latch, m_latch());
    chk("abort_oe", oDataOE, 0);
  endtask

  typedef struct { logic rw; logic [4:0] addr; logic [7:0] data; logic [7:0] exp; } vec_t;
  vec_t vt[12];

  initial begin
    vt[0]  = '{1'b0, 5'h04, 8'h5A, 8'h00};
    vt[1]  = '{1'b1, 5'h00, 8'h00, 8'h5A};
    vt[2]  = '{1'b1, 5'h1B, 8'h00, 8'hC3};
    vt[3]  = '{1'b1, 5'h00, 8'h00, 8'hC3};
    vt[4]  = '{1'b0, 5'h1F, 8'h77, 8'h00};
    vt[5]  = '{1'b1, 5'h1F, 8'h00, 8'h77};
    vt[6]  = '{1'b1, 5'h19, 8'h00, 8'h11};
    vt[7]  = '{1'b1, 5'h1A, 8'h00, 8'h22};
    vt[8]  = '{1'b1, 5'h1C, 8'h00, 8'hE3};
    vt[9]  = '{1'b1, 5'h05, 8'h00, 8'hE3};
    vt[10] = '{1'b0, 5'h19, 8'h99, 8'h00};
    vt[11] = '{1'b1, 5'h1D, 8'h00, 8'h99};

    repeat (3) @(negedge clk);
    chk("rst_we", oWE, 0);
    chk("rst_oe", oDataOE, 0);
    chk("rst_data", oData, 0);
    chk("rst_addr", oAddr, 0);
    chk("rst_wdata", oDataW, 0);
    chk("rst_latch", dut.bus_latch, 0);
    chk("rst_cnt", dut.decay_cnt, 0);
    chk("rst_state", int'(dut.state), int'(IDLE));
    iRstN = 1'b1;
    repeat (3) @(negedge clk);

    // Register table, including the 0x2A write and the 0x1B read corners
    do_cycle(1'b0, 5'h01, 8'h2A, 8'h00);
    foreach (vt[i]) do_cycle(vt[i].rw, vt[i].addr, vt[i].data, vt[i].exp);

    // Decay: the latch survives DECAY-1 ticks and clears on the last one
    do_cycle(1'b0, 5'h04, 8'h5A, 8'h00);
    do_cycle(1'b1, 5'h00, 8'h00, 8'h5A);
    repeat (DECAY - 1) tick();
    chk("decay_hold", dut.bus_latch, 8'h5A);
    chk("decay_cnt1", dut.decay_cnt, 1);
    tick();
    chk("decay_clear", dut.bus_latch, 8'h00);
    do_cycle(1'b1, 5'h00, 8'h00, 8'h00);

    // Abort a write with chip select mid-cycle
    do_cycle(1'b0, 5'h02, 8'h3C, 8'h00);
    do_abort(1'b0, 5'h03, 8'hF0);
    do_cycle(1'b1, 5'h00, 8'h00, 8'h3C);

    // Write commit lands on the same clk as the final decay tick
    do_cycle(1'b0, 5'h02, 8'h11, 8'h00);
    repeat (DECAY - 1) tick();
    chk("coin_pre_cnt", dut.decay_cnt, 1);
    bus_open(1'b0, 5'h07, 8'hB7);
    iPhi2 = 1'b0;
    repeat (2) @(negedge clk);
    clkEn = 1'b1;
    @(negedge clk);
    clkEn = 1'b0;
    chk("coin_we", oWE, 1);
    chk("coin_latch", dut.bus_latch, 8'hB7);
    chk("coin_cnt", dut.decay_cnt, DECAY);
    @(negedge clk);
    bus_close();
    m_val = 8'hB7; m_ticks = 0;

    // Reset pulsed in the middle of a write
    begin
      int p0;
      bus_open(1'b0, 5'h03, 8'h33);
      chk("mid_wr_state", int'(dut.state), int'(WR));
      iRstN = 1'b0;
      #2;
      chk("mrst_we", oWE, 0);
      chk("mrst_oe", oDataOE, 0);
      chk("mrst_data", oData, 0);
      chk("mrst_addr", oAddr, 0);
      chk("mrst_wdata", oDataW, 0);
      chk("mrst_latch", dut.bus_latch, 0);
      chk("mrst_cnt", dut.decay_cnt, 0);
      iPhi2 = 1'b0; iCSn = 1'b1; iRW = 1'b1;
      repeat (3) @(negedge clk);
      iRstN = 1'b1;
      p0 = we_pulses;
      repeat (10) @(negedge clk);
      chk("mrst_no_we", we_pulses - p0, 0);
      chk("mrst_idle", int'(dut.state), int'(IDLE));
      m_val = 8'h00; m_ticks = 0;
      do_cycle(1'b0, 5'h06, 8'hD6, 8'h00);
      do_cycle(1'b1, 5'h06, 8'h00, 8'hD6);
    end

    // Random traffic against the reference model
    for (int n = 0; n < 60; n++) begin
      int op;
      logic [4:0] a;
      logic [7:0] d;
      op = $urandom_range(0, 9);
      a = 5'($urandom_range(0, 31));
      d = 8'($urandom);
      if (($urandom & 3) == 0) begin
        iPotX = 8'($urandom); iPotY = 8'($urandom);
        iOsc3 = 8'($urandom); iEnv3 = 8'($urandom);
      end
      if (op < 4) do_cycle(1'b0, a, d, 8'h00);
      else if (op < 8) do_cycle(1'b1, a, 8'h00, m_read(a));
      else if (op == 8) do_abort(1'($urandom_range(0, 1)), a, d);
      else repeat ($urandom_range(1, DECAY + 2)) tick();
    end
    do_cycle(1'b1, 5'h00, 8'h00, m_read(5'h00));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
